// File: rtl/w_ptr_handler_lvl.sv
// Write-side pointer controller for an asynchronous FIFO.
// It produces the binary and Gray write pointers, a registered full flag,
// the fill level as seen from the write side, a programmable almost-full
// flag and a sticky overflow flag.
//
// Handshake: w_en is the write request and w_accept is its acknowledge.
// A word is written to the RAM, and the pointer advances, only in a cycle
// where w_en=1 and full=0, which is exactly when w_accept=1. A request made
// while full is refused: it moves no pointer and sets overflow. The
// requester need not hold w_en after a refusal.
module w_ptr_handler_lvl #(
  parameter int PTR_WIDTH = 3,
  parameter int AF_RESET  = 2**PTR_WIDTH - 1
) (
  input  logic                 wclk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [PTR_WIDTH:0]   g_rptr_sync,
  input  logic [PTR_WIDTH:0]   af_thresh,
  input  logic                 af_thresh_we,
  input  logic                 ovf_clr,
  output logic                 w_accept,
  output logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wr_level,
  output logic                 overflow
);

  // DEPTH expressed in pointer width: only the MSB is set.
  localparam logic [PTR_WIDTH:0] DEPTH_P = {1'b1, {PTR_WIDTH{1'b0}}};
  // A reset threshold above DEPTH behaves the same as DEPTH, so clamp it once.
  localparam logic [PTR_WIDTH:0] AF_RESET_C =
    (AF_RESET > 2**PTR_WIDTH) ? DEPTH_P : (PTR_WIDTH+1)'(AF_RESET);

  logic [PTR_WIDTH:0] b_rptr_sync;
  logic [PTR_WIDTH:0] b_wptr_next;
  logic [PTR_WIDTH:0] g_wptr_next;
  logic [PTR_WIDTH:0] lvl_next;
  logic [PTR_WIDTH:0] thresh_q;
  logic               full_next;

  // Convert the synchronised Gray read pointer back to binary.
  always_comb begin
    b_rptr_sync = '0;
    b_rptr_sync[PTR_WIDTH] = g_rptr_sync[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      b_rptr_sync[i] = b_rptr_sync[i+1] ^ g_rptr_sync[i];
    end
  end

  // Accept the write, advance the pointers and work out the next flags.
  always_comb begin
    w_accept    = w_en & ~full;
    b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, w_accept};
    g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1);
    lvl_next    = b_wptr_next - b_rptr_sync;
    // Full when the write pointer is a whole lap ahead of the read pointer:
    // in Gray code that means the top two bits are inverted and the rest match.
    full_next   = (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                                   g_rptr_sync[PTR_WIDTH-2:0]});
  end

  // Pointers, level and flags register the next-state values every cycle.
  always_ff @(posedge wclk) begin
    if (rst) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      wr_level    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      b_wptr      <= b_wptr_next;
      g_wptr      <= g_wptr_next;
      wr_level    <= lvl_next;
      full        <= full_next;
      almost_full <= (lvl_next >= thresh_q);
    end
  end

  // Threshold register; values beyond DEPTH are clamped on load.
  always_ff @(posedge wclk) begin
    if (rst) begin
      thresh_q <= AF_RESET_C;
    end else if (af_thresh_we) begin
      thresh_q <= (af_thresh > DEPTH_P) ? DEPTH_P : af_thresh;
    end
  end

  // Sticky overflow; a new refused write wins over a clear in the same cycle.
  always_ff @(posedge wclk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (w_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_w_ptr_handler_lvl.sv
// Bench for w_ptr_handler_lvl at PTR_WIDTH=3 (DEPTH=8, AF_RESET=7).
// The reference model counts words written and read as plain integers;
// pointers, level and flags are derived from those counts.
module tb_w_ptr_handler_lvl;

  localparam int PW    = 3;
  localparam int DEPTH = 8;
  localparam int W     = 11;

  // ---------------- clock / reset ----------------
  logic        wclk;
  logic        rst;
  logic        w_en;
  logic [3:0]  g_rptr_sync;
  logic [3:0]  af_thresh;
  logic        af_thresh_we;
  logic        ovf_clr;
  logic        w_accept;
  logic [3:0]  b_wptr;
  logic [3:0]  g_wptr;
  logic        full;
  logic        almost_full;
  logic [3:0]  wr_level;
  logic        overflow;

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  w_ptr_handler_lvl #(.PTR_WIDTH(PW), .AF_RESET(7)) dut (
    .wclk         (wclk),
    .rst          (rst),
    .w_en         (w_en),
    .g_rptr_sync  (g_rptr_sync),
    .af_thresh    (af_thresh),
    .af_thresh_we (af_thresh_we),
    .ovf_clr      (ovf_clr),
    .w_accept     (w_accept),
    .b_wptr       (b_wptr),
    .g_wptr       (g_wptr),
    .full         (full),
    .almost_full  (almost_full),
    .wr_level     (wr_level),
    .overflow     (overflow)
  );

  // ---------------- reference model state ----------------
  int         checks;
  int         failures;
  int         m_wr;       // total words accepted since reset
  int         m_rd;       // total words read, as seen through g_rptr_sync
  int         m_th;       // threshold in effect
  logic       m_full;
  logic       m_af;
  logic       m_ovf;
  logic [W-1:0] exp_q[$];

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic we, input int rd, input logic clr,
                       input logic twe, input logic [3:0] th, input logic r);
    logic         acc;
    logic         old_full;
    int           lvl;
    logic [3:0]   rd4;
    logic [3:0]   gr;
    logic [3:0]   eb;
    logic [W-1:0] e;
    rd4          = rd[3:0];
    gr           = to_gray(rd4);
    w_en         = we;
    g_rptr_sync  = gr;
    ovf_clr      = clr;
    af_thresh_we = twe;
    af_thresh    = th;
    rst          = r;
    #1;
    acc = we && !m_full;
    check("w_accept", {31'd0, w_accept}, {31'd0, acc});
    @(posedge wclk);
    if (r) begin
      m_wr = 0; m_rd = 0; m_th = 7;
      m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    end else begin
      old_full = m_full;
      m_wr     = m_wr + int'(acc);
      m_rd     = rd;
      lvl      = m_wr - m_rd;
      m_full   = (lvl == DEPTH);
      m_af     = (lvl >= m_th);
      if (we && old_full) m_ovf = 1'b1;
      else if (clr)       m_ovf = 1'b0;
      if (twe) m_th = (int'(th) > DEPTH) ? DEPTH : int'(th);
    end
    lvl = m_wr - m_rd;
    eb  = m_wr[3:0];
    exp_q.push_back({eb, m_full, m_af, lvl[3:0], m_ovf});
    #1;
    e = exp_q.pop_front();
    check("b_wptr",      {28'd0, b_wptr},      {28'd0, e[10:7]});
    check("g_wptr",      {28'd0, g_wptr},      {28'd0, to_gray(e[10:7])});
    check("full",        {31'd0, full},        {31'd0, e[6]});
    check("almost_full", {31'd0, almost_full}, {31'd0, e[5]});
    check("wr_level",    {28'd0, wr_level},    {28'd0, e[4:1]});
    check("overflow",    {31'd0, overflow},    {31'd0, e[0]});
    if (!r) begin
      // Second form of full: write pointer one lap ahead of the read pointer in Gray code.
      check("full_gray_form", {31'd0, full},
            {31'd0, (to_gray(e[10:7]) == {~gr[3:2], gr[1:0]})});
    end
  endtask

  // ---------------- directed then random sequence ----------------
  initial begin
    int         rd;
    logic [3:0] prev_g;
    checks = 0; failures = 0;
    m_wr = 0; m_rd = 0; m_th = 7;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    rst = 1'b1; w_en = 1'b0; g_rptr_sync = '0;
    af_thresh = '0; af_thresh_we = 1'b0; ovf_clr = 1'b0;

    // Reset held for two cycles with a write request pending.
    cycle(1'b1, 0, 1'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b1, 0, 1'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Fill: ten requests, eight accepted, two refused.
    for (int i = 0; i < 10; i++) cycle(1'b1, 0, 1'b0, 1'b0, 4'd0, 1'b0);
    check("fill_b_wptr", {28'd0, b_wptr}, 32'h8);
    check("fill_g_wptr", {28'd0, g_wptr}, 32'hC);
    check("fill_ovf",    {31'd0, overflow}, 32'h1);

    // Overflow clear, then a clear that loses to a fresh refused write.
    cycle(1'b0, 0, 1'b1, 1'b0, 4'd0, 1'b0);
    check("ovf_cleared", {31'd0, overflow}, 32'h0);
    cycle(1'b1, 0, 1'b1, 1'b0, 4'd0, 1'b0);
    check("ovf_set_wins", {31'd0, overflow}, 32'h1);

    // Drain three words through the synchronised read pointer.
    for (int i = 1; i <= 3; i++) cycle(1'b0, i, 1'b0, 1'b0, 4'd0, 1'b0);
    check("drain_level", {28'd0, wr_level}, 32'h5);

    // Wrap: stream 40 writes with the read pointer two words behind.
    prev_g = g_wptr;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, m_wr - 1, 1'b0, 1'b0, 4'd0, 1'b0);
      check("wrap_level", {28'd0, wr_level}, 32'h2);
      check("gray_1bit", $countones(prev_g ^ g_wptr), 32'd1);
      if (m_wr % 16 == 0) begin
        check("wrap_g_prev", {28'd0, prev_g}, 32'h8);
        check("wrap_g_zero", {28'd0, g_wptr}, 32'h0);
      end
      prev_g = g_wptr;
    end

    // Threshold 3 at level 2, then one more word raises almost_full.
    rd = m_wr - 2;
    cycle(1'b0, rd, 1'b0, 1'b1, 4'd3, 1'b0);
    cycle(1'b1, rd, 1'b0, 1'b0, 4'd0, 1'b0);
    check("af_at_3", {31'd0, almost_full}, 32'h1);

    // Threshold 12 clamps to 8: almost_full tracks full while filling.
    cycle(1'b0, rd, 1'b0, 1'b1, 4'd12, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, rd, 1'b0, 1'b0, 4'd0, 1'b0);
      check("af_eq_full", {31'd0, almost_full}, {31'd0, full});
    end

    // Random traffic with occasional reads, clears, threshold loads and resets.
    rd = m_rd;
    for (int i = 0; i < 500; i++) begin
      logic we, clr, twe, r;
      logic [3:0] th;
      we  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 7) == 0);
      twe = ($urandom_range(0, 15) == 0);
      th  = 4'($urandom_range(0, 15));
      r   = ($urandom_range(0, 99) == 0);
      if (rd < m_wr && $urandom_range(0, 1) == 1) rd = rd + 1;
      cycle(we, rd, clr, twe, th, r);
      if (r) rd = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/w_ptr_handler_lvl.md
Name: w_ptr_handler_lvl

Overview:
- Parametrised write-side pointer controller for the asynchronous FIFO; sits in the write clock domain next to the write-port RAM.
- Generates binary and Gray write pointers and a registered full flag.
- Adds a registered fill level, a programmable almost-full flag, a write-accept strobe and a sticky overflow error flag.
- The read pointer arrives Gray-coded and already synchronised into the write domain.

Parameters:
- PTR_WIDTH, 3: address bits. FIFO depth DEPTH = 2**PTR_WIDTH. Pointers are PTR_WIDTH+1 bits. Legal range is 2..10.
- AF_RESET, 2**PTR_WIDTH-1: reset value for the almost-full threshold. Used when af_thresh_we has never been pulsed.

Ports:
- wclk  in  1  write clock
- rst  in  1  synchronous reset, active-high
- w_en  in  1  write request
- g_rptr_sync  in  PTR_WIDTH+1  Gray read pointer, synchronised to wclk
- af_thresh  in  PTR_WIDTH+1  almost-full threshold (level units)
- af_thresh_we  in  1  load af_thresh into the internal threshold register
- ovf_clr  in  1  clear sticky overflow
- w_accept  out  1  combinational: w_en & ~full (RAM write strobe)
- b_wptr  out  PTR_WIDTH+1  binary write pointer (RAM address = low PTR_WIDTH bits)
- g_wptr  out  PTR_WIDTH+1  Gray write pointer, to the read-domain synchroniser
- full  out  1  registered full
- almost_full  out  1  registered level >= threshold
- wr_level  out  PTR_WIDTH+1  registered words stored, write-side view (0..DEPTH)
- overflow  out  1  sticky: a write was attempted while full

Behaviour:
- Clock and reset:
  - Single clock wclk.
  - rst is synchronous, active-high, sampled on the wclk rising edge, and overrides all other inputs.
- Reset values:
  - b_wptr=0, g_wptr=0, full=0, almost_full=0, wr_level=0, overflow=0.
  - Threshold register = AF_RESET.
  - w_accept follows the reset value of full, so it is 0 while w_en=0.
- Read pointer decode (combinational):
  - b_rptr_sync[i] = XOR of g_rptr_sync[PTR_WIDTH:i].
- Next write pointer:
  - b_wptr_next = b_wptr + w_accept, modulo 2**(PTR_WIDTH+1). It wraps naturally, and the MSB toggles per lap.
  - g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1).
- Level:
  - lvl_next = (b_wptr_next - b_rptr_sync) mod 2**(PTR_WIDTH+1).
  - Valid range is 0..DEPTH. The read side can never pass the write side, so larger values cannot occur with legal inputs.
- Registered updates each cycle (not in reset):
  - b_wptr <= b_wptr_next; g_wptr <= g_wptr_next.
  - wr_level <= lvl_next.
  - full <= (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]}). This is equivalent to lvl_next == DEPTH. Both forms must agree, and verification checks both.
  - almost_full <= (lvl_next >= threshold), using the threshold value in effect during that cycle.
- Threshold register:
  - Loaded from af_thresh on any cycle with af_thresh_we=1. The new value affects almost_full from the following cycle's update.
  - Values > DEPTH are clamped to DEPTH on load.
  - Threshold 0 makes almost_full=1 from the first cycle after reset.
- Overflow:
  - Set when w_en=1 and full=1. Once set, it stays set until ovf_clr=1 or rst.
  - If set and clear occur in the same cycle, set wins.
  - A refused write never changes any pointer.
- Latency:
  - w_accept has zero latency.
  - Pointers, full, almost_full and wr_level reflect an accepted write one cycle later.
  - A read becomes visible only after it appears on g_rptr_sync. Full and level therefore lag reads and are conservative, never optimistic.
- Simultaneous events:
  - An accepted write plus a read pointer advance in the same cycle leaves the level unchanged.
  - Full deasserts only on a cycle in which the synchronised read pointer has advanced.
- Wrap-around:
  - Pointer wrap at 2**(PTR_WIDTH+1)-1 -> 0 must produce correct full, level and Gray values. Gray codes across wrap differ in exactly 1 bit.
- Reset mid-operation:
  - All outputs return to reset values on the next edge, independent of w_en.
  - The threshold register also returns to AF_RESET.
  - An in-flight write request during that cycle is discarded.

Test Plan (PTR_WIDTH=3, DEPTH=8, AF_RESET=7):
- Reset: rst=1 for 2 cycles with w_en=1 -> all outputs 0, pointers stay 0. After release with w_en=0 and g_rptr_sync=0 -> wr_level=0, full=0.
- Fill: g_rptr_sync=0, w_en=1 for 10 cycles.
  - w_accept=1 for exactly 8 cycles; b_wptr ends at 8 (4'b1000), g_wptr ends at 4'b1100.
  - almost_full rises when wr_level=7; full=1 when wr_level=8.
  - The 9th and 10th requests give w_accept=0 and set overflow=1.
- Overflow clear: pulse ovf_clr with w_en=0 -> overflow=0 next cycle. Pulse ovf_clr with w_en=1 while full -> overflow stays 1.
- Drain: from full, step g_rptr_sync through Gray 1,3,2 with w_en=0 -> wr_level goes 7,6,5 on successive cycles; full=0 after the first step; almost_full=0 once wr_level<7.
- Wrap: stream 40 writes with g_rptr_sync tracking b_wptr-2 (Gray-coded) -> wr_level steady at 2, full never asserts. Crossing b_wptr 15->0 gives g_wptr 4'b1000->4'b0000.
- Threshold: load af_thresh=3 at level 2, then write one word -> almost_full=1 when wr_level=3. Load af_thresh=12 -> clamped to 8, and almost_full coincides with full.
